// File: rtl/mem_bus_bridge.sv
// Bridges split instruction/data ports onto one handshaked memory bus with timeout.
// Optional: define MEM_BUS_WBUF_EN for a one-entry posted write buffer (W_WAIT drain state).
module mem_bus_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255,
  parameter int SW      = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_ce_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  input  logic          d_ce_i,
  input  logic          d_we_i,
  input  logic [SW-1:0] d_sel_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          stallreq_if_o,
  output logic          stallreq_mem_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [SW-1:0] bus_sel_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rdata_i,
  output logic          bus_err_o,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST_C = CW'(TMO_LAST);
  localparam logic TMO_ON = (TMO_CYC > 0);

  // Handshake: bus_req_o rises on entry to a wait state and holds addr/we/sel/wdata
  // stable until the one-cycle bus_ack_i (or a timeout) ends the transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2
`ifdef MEM_BUS_WBUF_EN
    , W_WAIT = 2'd3
`endif
  } state_t;

  state_t        r_state, w_next;
  logic          r_if_done, r_d_done, r_bus_err, r_bus_req, r_bus_we;
  logic [CW-1:0] r_tmo_cnt;
  logic [AW-1:0] r_bus_addr;
  logic [SW-1:0] r_bus_sel;
  logic [DW-1:0] r_bus_wdata, r_if_data, r_d_rdata;
  logic          w_stall_if, w_stall_mem, w_release, w_d_go, w_i_go;
  logic          w_ack, w_tmo, w_fin;
  logic [DW-1:0] w_rdata;

`ifdef MEM_BUS_WBUF_EN
  logic          r_wb_full;
  logic [AW-1:0] r_wb_addr;
  logic [SW-1:0] r_wb_sel;
  logic [DW-1:0] r_wb_data;
  logic          w_wb_accept;

  assign w_wb_accept = d_ce_i & ~r_d_done & d_we_i & ~r_wb_full;
  assign w_stall_mem = d_ce_i & ~r_d_done & ~(d_we_i & ~r_wb_full);
  assign w_d_go      = d_ce_i & ~r_d_done & ~d_we_i;
`else
  assign w_stall_mem = d_ce_i & ~r_d_done;
  assign w_d_go      = d_ce_i & ~r_d_done;
`endif

  assign w_stall_if = if_ce_i & ~r_if_done;
  assign w_i_go     = w_stall_if;
  assign w_release  = ~w_stall_if & ~w_stall_mem;

  // A late ack wins over a timeout landing in the same cycle.
  assign w_ack   = bus_ack_i & (r_state != IDLE);
  assign w_tmo   = TMO_ON & (r_state != IDLE) & ~bus_ack_i & (r_tmo_cnt == TMO_LAST_C);
  assign w_fin   = w_ack | w_tmo;
  assign w_rdata = bus_ack_i ? bus_rdata_i : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
`ifdef MEM_BUS_WBUF_EN
        if (r_wb_full)   w_next = W_WAIT;
        else
`endif
        if (w_d_go)      w_next = D_WAIT;
        else if (w_i_go) w_next = I_WAIT;
      end
      default: if (w_fin) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
      r_tmo_cnt   <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_req <= (w_next != IDLE);
      r_tmo_cnt <= ((r_state == IDLE) || w_fin) ? '0 : r_tmo_cnt + CW'(1);
      if (w_tmo) r_bus_err <= 1'b1;
      if (r_state == IDLE) begin
        case (w_next)
          D_WAIT: begin
            r_bus_addr  <= d_addr_i;
            r_bus_we    <= d_we_i;
            r_bus_sel   <= d_sel_i;
            r_bus_wdata <= d_wdata_i;
          end
          I_WAIT: begin
            r_bus_addr  <= if_addr_i;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '1;
            r_bus_wdata <= '0;
          end
`ifdef MEM_BUS_WBUF_EN
          W_WAIT: begin
            r_bus_addr  <= r_wb_addr;
            r_bus_we    <= 1'b1;
            r_bus_sel   <= r_wb_sel;
            r_bus_wdata <= r_wb_data;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Done flags only clear in the release cycle, so a finished channel is never
  // re-issued while the other one still stalls the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_if_data <= '0;
      r_d_rdata <= '0;
    end else if (w_release) begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      if (w_fin && (r_state == I_WAIT) && if_ce_i) begin
        r_if_done <= 1'b1;
        r_if_data <= w_rdata;
      end
      if (w_fin && (r_state == D_WAIT) && d_ce_i) begin
        r_d_done  <= 1'b1;
        r_d_rdata <= r_bus_we ? '0 : w_rdata;
      end
`ifdef MEM_BUS_WBUF_EN
      if (w_wb_accept) r_d_done <= 1'b1;
`endif
    end
  end

`ifdef MEM_BUS_WBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_full <= 1'b0;
      r_wb_addr <= '0;
      r_wb_sel  <= '0;
      r_wb_data <= '0;
    end else if (w_wb_accept) begin
      r_wb_full <= 1'b1;
      r_wb_addr <= d_addr_i;
      r_wb_sel  <= d_sel_i;
      r_wb_data <= d_wdata_i;
    end else if (w_fin && (r_state == W_WAIT)) begin
      r_wb_full <= 1'b0;
    end
  end
`endif

  assign if_data_o      = r_if_data;
  assign d_rdata_o      = r_d_rdata;
  assign stallreq_if_o  = w_stall_if;
  assign stallreq_mem_o = w_stall_mem;
  assign bus_req_o      = r_bus_req;
  assign bus_we_o       = r_bus_we;
  assign bus_addr_o     = r_bus_addr;
  assign bus_sel_o      = r_bus_sel;
  assign bus_wdata_o    = r_bus_wdata;
  assign bus_err_o      = r_bus_err;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: bus responder/monitor, driver tasks, scoreboard queue.
module tb_mem_bus_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_ce_i, d_ce_i, d_we_i, bus_ack_i;
  logic [AW-1:0] if_addr_i, d_addr_i;
  logic [SW-1:0] d_sel_i;
  logic [DW-1:0] d_wdata_i, bus_rdata_i;
  logic [DW-1:0] if_data_o, d_rdata_o, bus_wdata_o;
  logic          stallreq_if_o, stallreq_mem_o, bus_req_o, bus_we_o, bus_err_o;
  logic [AW-1:0] bus_addr_o;
  logic [SW-1:0] bus_sel_o;
  logic [1:0]    dbg_state_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
  } bus_rec_t;

  logic [DW-1:0] exp_q[$];
  bus_rec_t      bus_log[$];
  bus_rec_t      mon_cur;
  logic          mon_prev;
  int            wcnt;
  int            ack_delay = 0;
  bit            resp_en = 1'b1;
  int            n_cmp = 0;
  int            n_err = 0;

  mem_bus_bridge #(.AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // bus responder + monitor: logs each transfer and checks fields stay stable
  initial begin
    bus_ack_i = 1'b0;
    bus_rdata_i = '0;
    mon_prev = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (bus_req_o && !mon_prev) begin
        mon_cur = {bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o};
        bus_log.push_back(mon_cur);
      end else if (bus_req_o) begin
        check_eq("bus_hold", {bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o}, mon_cur);
      end
      mon_prev = bus_req_o;
      if (bus_req_o && resp_en) begin
        if (wcnt == ack_delay) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = rd_model(bus_addr_o);
        end else begin
          bus_ack_i = 1'b0;
          bus_rdata_i = $urandom;
        end
        wcnt++;
      end else begin
        bus_ack_i = 1'b0;
        if (!bus_req_o) wcnt = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_d(input bit chk, output int stalls);
    stalls = 0;
    @(negedge clk);
    while (stallreq_mem_o && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    check_eq("d_done_bound", stallreq_mem_o, 1'b0);
    if (chk && exp_q.size() > 0) check_eq("d_rdata", d_rdata_o, exp_q.pop_front());
  endtask

  task automatic d_access(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int dly, input bit en,
                          output int stalls);
    bit chk;
    ack_delay = dly;
    resp_en = en;
    d_ce_i = 1'b1;
    d_we_i = we;
    d_sel_i = sel;
    d_addr_i = addr;
    d_wdata_i = wdata;
    chk = !we;
`ifndef MEM_BUS_WBUF_EN
    chk = 1'b1;
`endif
    if (chk) exp_q.push_back((!en || we) ? '0 : rd_model(addr));
    wait_d(chk, stalls);
  endtask

  task automatic f_access(input logic [AW-1:0] addr, input int dly);
    int c;
    ack_delay = dly;
    resp_en = 1'b1;
    if_ce_i = 1'b1;
    if_addr_i = addr;
    exp_q.push_back(rd_model(addr));
    c = 0;
    @(negedge clk);
    while (stallreq_if_o && c < 40) begin
      c++;
      @(negedge clk);
    end
    check_eq("if_done_bound", stallreq_if_o, 1'b0);
    check_eq("if_data", if_data_o, exp_q.pop_front());
  endtask

  task automatic both_access(input logic [AW-1:0] da, input logic [AW-1:0] ia, input int dly,
                             output int mf, output int ff);
    ack_delay = dly;
    resp_en = 1'b1;
    d_ce_i = 1'b1;
    d_we_i = 1'b0;
    d_sel_i = '1;
    d_addr_i = da;
    if_ce_i = 1'b1;
    if_addr_i = ia;
    exp_q.push_back(rd_model(da));
    exp_q.push_back(rd_model(ia));
    mf = -1;
    ff = -1;
    for (int c = 0; c < 80 && (mf < 0 || ff < 0); c++) begin
      @(negedge clk);
      if (mf < 0 && !stallreq_mem_o) begin
        mf = c;
        check_eq("both_d_rdata", d_rdata_o, exp_q.pop_front());
      end
      if (ff < 0 && !stallreq_if_o) begin
        ff = c;
        check_eq("both_if_data", if_data_o, exp_q.pop_front());
      end
    end
    check_eq("both_bound", (mf >= 0 && ff >= 0), 1'b1);
  endtask

  task automatic idle_all();
    @(posedge clk);
    #1;
    d_ce_i = 1'b0;
    if_ce_i = 1'b0;
    d_we_i = 1'b0;
  endtask

  // main sequence
  initial begin
    int st, mf, ff, c, kind;
    logic [DW-1:0] tmp;
    logic [AW-1:0] a1;

    rst = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0;
    d_ce_i = 1'b0; d_we_i = 1'b0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_bus_req", bus_req_o, 1'b0);
    check_eq("rst_state", dbg_state_o, 2'd0);
    check_eq("rst_bus_err", bus_err_o, 1'b0);
    check_eq("rst_rdata", {if_data_o, d_rdata_o}, 64'd0);
    check_eq("rst_bus_fields", {bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}, '0);
    check_eq("rst_stalls", {stallreq_if_o, stallreq_mem_o}, 2'b00);
    rst = 1'b1;

    // 1: load, ack 3 cycles after req, then re-issue after one release cycle
    tmp = 32'hDEAD_BEEF ^ 32'h5A5A_0F0F;
    a1 = {tmp[15:0], tmp[31:16]};
    @(posedge clk); #1;
    d_access(1'b0, 4'hF, a1, '0, 2, 1'b1, st);
    check_eq("t1_stall_cycles", st, 4);
    check_eq("t1_rdata_const", d_rdata_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    exp_q.push_back(rd_model(a1));
    @(negedge clk);
    check_eq("t1_reissue", stallreq_mem_o, 1'b1);
    wait_d(1'b1, st);
    idle_all();

    // 2: simultaneous fetch and load, data first, no data re-issue
    bus_log.delete();
    both_access(32'h0000_1000, 32'h0000_2000, 1, mf, ff);
    check_eq("t2_order", (mf < ff), 1'b1);
    check_eq("t2_bus_count", bus_log.size(), 2);
    if (bus_log.size() >= 2) begin
      check_eq("t2_first_addr", bus_log[0].addr, 32'h0000_1000);
      check_eq("t2_second_addr", {bus_log[1].addr, bus_log[1].sel}, {32'h0000_2000, 4'hF});
    end
    idle_all();

    // 3: store with partial byte select
    bus_log.delete();
    d_access(1'b1, 4'b0011, 32'h0000_3000, 32'h1234_5678, 2, 1'b1, st);
    idle_all();
    repeat (8) @(negedge clk);
    check_eq("t3_bus_count", bus_log.size(), 1);
    if (bus_log.size() >= 1)
      check_eq("t3_store_fields", {bus_log[0].we, bus_log[0].sel, bus_log[0].wdata},
               {1'b1, 4'b0011, 32'h1234_5678});
    check_eq("t3_no_err", bus_err_o, 1'b0);

    // 4: no ack -> timeout after 4 wait cycles, sticky error
    @(posedge clk); #1;
    d_access(1'b0, 4'hF, 32'h0000_4000, '0, 0, 1'b0, st);
    check_eq("t4_stall_cycles", st, 5);
    check_eq("t4_err_set", bus_err_o, 1'b1);
    idle_all();
    d_access(1'b0, 4'hF, 32'h0000_4400, '0, 0, 1'b1, st);
    check_eq("t4_err_sticky", bus_err_o, 1'b1);
    idle_all();

    // 5: asynchronous reset in the middle of a fetch
    resp_en = 1'b0;
    if_ce_i = 1'b1;
    if_addr_i = 32'h0000_5000;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus_req_o && c < 10);
    check_eq("t5_req_up", bus_req_o, 1'b1);
    check_eq("t5_in_iwait", dbg_state_o, 2'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_req_async", bus_req_o, 1'b0);
    check_eq("t5_state", dbg_state_o, 2'd0);
    check_eq("t5_err_clr", bus_err_o, 1'b0);
    check_eq("t5_data_clr", {if_data_o, d_rdata_o, bus_sel_o}, '0);
    if_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    resp_en = 1'b1;

    // random mix of loads, stores, fetches and simultaneous pairs
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      kind = $urandom_range(0, 3);
      case (kind)
        0: d_access(1'b0, 4'hF, $urandom & 32'hFFFF_FFFC, '0, $urandom_range(0, 2), 1'b1, st);
        1: d_access(1'b1, 4'($urandom_range(1, 15)), $urandom & 32'hFFFF_FFFC, $urandom,
                    $urandom_range(0, 2), 1'b1, st);
        2: f_access($urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        default: begin
          both_access($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 2), mf, ff);
          check_eq("rnd_order", (mf < ff), 1'b1);
        end
      endcase
      idle_all();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    check_eq("rnd_no_err", bus_err_o, 1'b0);

`ifdef MEM_BUS_WBUF_EN
    // 6: posted store, then an immediate load that waits for the drain
    repeat (8) @(posedge clk);
    bus_log.delete();
    #1;
    ack_delay = 1;
    resp_en = 1'b1;
    d_ce_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
    d_addr_i = 32'h0000_6000; d_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("t6_store_no_stall", stallreq_mem_o, 1'b0);
    @(posedge clk); #1;
    d_we_i = 1'b0;
    d_addr_i = 32'h0000_6400;
    exp_q.push_back(rd_model(32'h0000_6400));
    wait_d(1'b1, st);
    check_eq("t6_load_stalled", (st >= 3), 1'b1);
    check_eq("t6_bus_count", bus_log.size(), 2);
    if (bus_log.size() >= 2)
      check_eq("t6_order", {bus_log[0].we, bus_log[0].addr, bus_log[1].we, bus_log[1].addr},
               {1'b1, 32'h0000_6000, 1'b0, 32'h0000_6400});
    idle_all();
`endif

    repeat (6) @(negedge clk);
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
